// File: rtl/regfile_pkg.sv
// regfile_pkg: shared constants for the multi-port register file.
//   DEF_DATA_W / DEF_ADDR_W / DEF_NUM_RD : default parameter values for regfile_mp
//   ZERO_REG                             : address of the hardwired-zero entry
package regfile_pkg;
  localparam int unsigned DEF_DATA_W = 32;
  localparam int unsigned DEF_ADDR_W = 5;
  localparam int unsigned DEF_NUM_RD = 2;
  localparam int unsigned ZERO_REG   = 0;
endpackage

// File: rtl/regfile_wr_decode.sv
// regfile_wr_decode: turns one (enable, address) pair into a one-hot vector over
// all register entries. Entry ZERO_REG is always masked so nothing can ever
// modify the hardwired-zero register or its busy bit.
// Ports:
//   en     in   enable for this port
//   addr   in   target entry
//   onehot out  one bit per entry, at most one bit set
module regfile_wr_decode
  import regfile_pkg::*;
#(
  parameter int unsigned ADDR_W = DEF_ADDR_W
) (
  input  logic                     en,
  input  logic [ADDR_W-1:0]        addr,
  output logic [(1<<ADDR_W)-1:0]   onehot
);

  localparam logic [ADDR_W-1:0] ZERO_ADDR = ZERO_REG[ADDR_W-1:0];

  always_comb begin
    onehot = '0;
    if (en && (addr != ZERO_ADDR)) begin
      onehot[addr] = 1'b1;
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// regfile_mp: multi-port register file with a per-entry pending (busy) scoreboard.
// Build option: define REGFILE_BYPASS_EN to forward same-cycle write data and
// busy clears to the read ports; undefined, reads show stored state only.
// Ports:
//   clk, rst                 rising-edge clock, asynchronous active-high reset
//   we0/waddr0/wdata0        write port 0 (ALU writeback)
//   we1/waddr1/wdata1        write port 1 (load writeback); also clears busy[waddr1]
//   busy_set/busy_addr       mark an entry pending when a load issues
//   raddr / rdata / rbusy    NUM_RD packed combinational read ports
//   dbg_addr / dbg_data      raw storage tap, never bypassed
// Valid/ready: there is no handshake; every enable is a single-cycle strobe
// sampled at the rising clock edge and has no back-pressure.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned ADDR_W = DEF_ADDR_W,
  parameter int unsigned NUM_RD = DEF_NUM_RD
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       we0,
  input  logic [ADDR_W-1:0]          waddr0,
  input  logic [DATA_W-1:0]          wdata0,
  input  logic                       we1,
  input  logic [ADDR_W-1:0]          waddr1,
  input  logic [DATA_W-1:0]          wdata1,
  input  logic                       busy_set,
  input  logic [ADDR_W-1:0]          busy_addr,
  input  logic [NUM_RD*ADDR_W-1:0]   raddr,
  output logic [NUM_RD*DATA_W-1:0]   rdata,
  output logic [NUM_RD-1:0]          rbusy,
  input  logic [ADDR_W-1:0]          dbg_addr,
  output logic [DATA_W-1:0]          dbg_data
);

  localparam int unsigned       DEPTH     = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] ZERO_ADDR = ZERO_REG[ADDR_W-1:0];

  logic [DEPTH-1:0]  we0_oh;
  logic [DEPTH-1:0]  we1_oh;
  logic [DEPTH-1:0]  bset_oh;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  logic [DEPTH-1:0]  busy_q;
  logic [DEPTH-1:0]  busy_d;

  regfile_wr_decode #(.ADDR_W(ADDR_W)) u_dec_we0 (
    .en(we0), .addr(waddr0), .onehot(we0_oh)
  );
  regfile_wr_decode #(.ADDR_W(ADDR_W)) u_dec_we1 (
    .en(we1), .addr(waddr1), .onehot(we1_oh)
  );
  regfile_wr_decode #(.ADDR_W(ADDR_W)) u_dec_bset (
    .en(busy_set), .addr(busy_addr), .onehot(bset_oh)
  );

  // Port 1 (load) overrides port 0 on a same-entry collision. The busy set is
  // OR-ed in last so a load issuing in the same cycle a load returns to the
  // same entry leaves it pending.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      mem_d[i] = mem_q[i];
      if (we1_oh[i]) begin
        mem_d[i] = wdata1;
      end else if (we0_oh[i]) begin
        mem_d[i] = wdata0;
      end
    end
    busy_d = (busy_q & ~we1_oh) | bset_oh;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      busy_q <= '0;
    end else begin
      mem_q  <= mem_d;
      busy_q <= busy_d;
    end
  end

  assign dbg_data = mem_q[dbg_addr];

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_W-1:0] addr_k;
    logic [DATA_W-1:0] data_k;
    logic              busy_k;

    assign addr_k = raddr[k*ADDR_W +: ADDR_W];

    always_comb begin
      data_k = mem_q[addr_k];
      busy_k = busy_q[addr_k];
`ifdef REGFILE_BYPASS_EN
      // Forwarding is suppressed during reset because those writes are dropped.
      if (!rst) begin
        if (we1_oh[addr_k]) begin
          data_k = wdata1;
          if (!bset_oh[addr_k]) begin
            busy_k = 1'b0;
          end
        end else if (we0_oh[addr_k]) begin
          data_k = wdata0;
        end
      end
`endif
      if (addr_k == ZERO_ADDR) begin
        data_k = '0;
        busy_k = 1'b0;
      end
    end

    assign rdata[k*DATA_W +: DATA_W] = data_k;
    assign rbusy[k]                  = busy_k;
  end

endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: directed bench for regfile_mp. Two instances: the default
// configuration (32/5/2) and a small one (16/3/4). A reference model of the
// register contents and pending bits is updated at every clock edge, and each
// falling edge compares every read port and the debug tap against it. Directed
// steps add hand-computed literal expectations.
module tb_regfile_mp;
  localparam int DW  = 32;
  localparam int AW  = 5;
  localparam int NR  = 2;
  localparam int SDW = 16;
  localparam int SAW = 3;
  localparam int SNR = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // default instance signals
  logic          we0, we1, busy_set;
  logic [AW-1:0] waddr0, waddr1, busy_addr, dbg_addr;
  logic [DW-1:0] wdata0, wdata1, dbg_data;
  logic [NR*AW-1:0] raddr;
  logic [NR*DW-1:0] rdata;
  logic [NR-1:0]    rbusy;

  // small instance signals
  logic           s_we0, s_we1, s_busy_set;
  logic [SAW-1:0] s_waddr0, s_waddr1, s_busy_addr, s_dbg_addr;
  logic [SDW-1:0] s_wdata0, s_wdata1, s_dbg_data;
  logic [SNR*SAW-1:0] s_raddr;
  logic [SNR*SDW-1:0] s_rdata;
  logic [SNR-1:0]     s_rbusy;

  int checks   = 0;
  int failures = 0;
  bit check_en = 1'b0;

  regfile_mp #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR)) dut (
    .clk(clk), .rst(rst),
    .we0(we0), .waddr0(waddr0), .wdata0(wdata0),
    .we1(we1), .waddr1(waddr1), .wdata1(wdata1),
    .busy_set(busy_set), .busy_addr(busy_addr),
    .raddr(raddr), .rdata(rdata), .rbusy(rbusy),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  regfile_mp #(.DATA_W(SDW), .ADDR_W(SAW), .NUM_RD(SNR)) dut_s (
    .clk(clk), .rst(rst),
    .we0(s_we0), .waddr0(s_waddr0), .wdata0(s_wdata0),
    .we1(s_we1), .waddr1(s_waddr1), .wdata1(s_wdata1),
    .busy_set(s_busy_set), .busy_addr(s_busy_addr),
    .raddr(s_raddr), .rdata(s_rdata), .rbusy(s_rbusy),
    .dbg_addr(s_dbg_addr), .dbg_data(s_dbg_data)
  );

  // ---------------- reference model ----------------
  logic [DW-1:0]  m_mem  [32];
  bit             m_busy [32];
  logic [SDW-1:0] s_mem  [8];
  bit             s_busy [8];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) begin m_mem[i] = '0; m_busy[i] = 1'b0; end
      for (int i = 0; i < 8; i++)  begin s_mem[i] = '0; s_busy[i] = 1'b0; end
    end else begin
      // later statements win: port 1 data over port 0, busy set over clear
      if (we0 && waddr0 != 0) m_mem[waddr0] = wdata0;
      if (we1 && waddr1 != 0) m_mem[waddr1] = wdata1;
      if (we1) m_busy[waddr1] = 1'b0;
      if (busy_set && busy_addr != 0) m_busy[busy_addr] = 1'b1;
      if (s_we0 && s_waddr0 != 0) s_mem[s_waddr0] = s_wdata0;
      if (s_we1 && s_waddr1 != 0) s_mem[s_waddr1] = s_wdata1;
      if (s_we1) s_busy[s_waddr1] = 1'b0;
      if (s_busy_set && s_busy_addr != 0) s_busy[s_busy_addr] = 1'b1;
    end
  end

  function automatic logic [DW-1:0] exp_rd(input logic [AW-1:0] a);
    if (a == 0) return '0;
`ifdef REGFILE_BYPASS_EN
    if (!rst && we1 && waddr1 == a) return wdata1;
    if (!rst && we0 && waddr0 == a) return wdata0;
`endif
    return m_mem[a];
  endfunction

  function automatic logic exp_bz(input logic [AW-1:0] a);
    if (a == 0) return 1'b0;
`ifdef REGFILE_BYPASS_EN
    if (!rst && we1 && waddr1 == a && !(busy_set && busy_addr == a)) return 1'b0;
`endif
    return m_busy[a];
  endfunction

  function automatic logic [SDW-1:0] s_exp_rd(input logic [SAW-1:0] a);
    if (a == 0) return '0;
`ifdef REGFILE_BYPASS_EN
    if (!rst && s_we1 && s_waddr1 == a) return s_wdata1;
    if (!rst && s_we0 && s_waddr0 == a) return s_wdata0;
`endif
    return s_mem[a];
  endfunction

  function automatic logic s_exp_bz(input logic [SAW-1:0] a);
    if (a == 0) return 1'b0;
`ifdef REGFILE_BYPASS_EN
    if (!rst && s_we1 && s_waddr1 == a && !(s_busy_set && s_busy_addr == a)) return 1'b0;
`endif
    return s_busy[a];
  endfunction

  // ---------------- scoreboard helpers ----------------
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin : compare
    if (check_en) begin
      for (int k = 0; k < NR; k++) begin
        chk($sformatf("model rdata[%0d]", k), rdata[k*DW +: DW], exp_rd(raddr[k*AW +: AW]));
        chk($sformatf("model rbusy[%0d]", k), rbusy[k], exp_bz(raddr[k*AW +: AW]));
      end
      chk("model dbg_data", dbg_data, m_mem[dbg_addr]);
      for (int k = 0; k < SNR; k++) begin
        chk($sformatf("model s_rdata[%0d]", k), s_rdata[k*SDW +: SDW], s_exp_rd(s_raddr[k*SAW +: SAW]));
        chk($sformatf("model s_rbusy[%0d]", k), s_rbusy[k], s_exp_bz(s_raddr[k*SAW +: SAW]));
      end
      chk("model s_dbg_data", s_dbg_data, s_mem[s_dbg_addr]);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic clr();
    we0 = 0; waddr0 = '0; wdata0 = '0;
    we1 = 0; waddr1 = '0; wdata1 = '0;
    busy_set = 0; busy_addr = '0;
    s_we0 = 0; s_waddr0 = '0; s_wdata0 = '0;
    s_we1 = 0; s_waddr1 = '0; s_wdata1 = '0;
    s_busy_set = 0; s_busy_addr = '0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_rd(input int k, input logic [AW-1:0] a);
    raddr[k*AW +: AW] = a;
  endtask

  task automatic wr0(input logic [AW-1:0] a, input logic [DW-1:0] d);
    we0 = 1'b1; waddr0 = a; wdata0 = d;
  endtask

  task automatic wr1(input logic [AW-1:0] a, input logic [DW-1:0] d);
    we1 = 1'b1; waddr1 = a; wdata1 = d;
  endtask

  task automatic bset(input logic [AW-1:0] a);
    busy_set = 1'b1; busy_addr = a;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    rst = 1'b1;
    clr();
    raddr = '0; dbg_addr = '0; s_raddr = '0; s_dbg_addr = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check_en = 1'b1;

    // reset state
    set_rd(0, 5'd5); set_rd(1, 5'd9); dbg_addr = 5'd5;
    @(negedge clk);
    chk("reset rdata0", rdata[31:0], 32'h0);
    chk("reset rbusy", rbusy, 2'b00);
    chk("reset dbg", dbg_data, 32'h0);

    // 1. asynchronous reset clears stored data and busy immediately
    step();
    wr0(5'd5, 32'h1234); bset(5'd5);
    step(); clr();
    @(negedge clk);
    chk("t1 rdata r5", rdata[31:0], 32'h1234);
    chk("t1 rbusy r5", rbusy[0], 1'b1);
    chk("t1 dbg r5", dbg_data, 32'h1234);
    #1 rst = 1'b1;
    wr0(5'd6, 32'h77);
    #1;
    chk("t1 async rdata", rdata[31:0], 32'h0);
    chk("t1 async rbusy", rbusy[0], 1'b0);
    chk("t1 async dbg", dbg_data, 32'h0);
    step();
    rst = 1'b0; clr();
    set_rd(1, 5'd6);
    @(negedge clk);
    chk("t1 write during reset dropped", rdata[63:32], 32'h0);

    // 2. write/read and r0 hardwired zero
    step();
    wr0(5'd4, 32'hDEADBEEF);
    step(); clr();
    set_rd(0, 5'd4);
    wr0(5'd0, 32'hFFFF);
    @(negedge clk);
    chk("t2 rdata r4", rdata[31:0], 32'hDEADBEEF);
    step(); clr();
    set_rd(1, 5'd0); dbg_addr = 5'd0;
    @(negedge clk);
    chk("t2 r0 read", rdata[63:32], 32'h0);
    chk("t2 r0 dbg", dbg_data, 32'h0);

    // 3. same-address collision: port 1 wins
    step();
    wr0(5'd17, 32'h11); wr1(5'd17, 32'h22);
    step(); clr();
    set_rd(0, 5'd17); dbg_addr = 5'd17;
    @(negedge clk);
    chk("t3 collision r17", rdata[31:0], 32'h22);
    chk("t3 collision dbg", dbg_data, 32'h22);

    // 4. scoreboard
    step();
    bset(5'd16);
    step(); clr();
    set_rd(1, 5'd16);
    @(negedge clk);
    chk("t4 busy r16 set", rbusy[1], 1'b1);
    step();
    wr1(5'd16, 32'h5);
    @(negedge clk);
`ifdef REGFILE_BYPASS_EN
    chk("t4 bypass busy r16", rbusy[1], 1'b0);
    chk("t4 bypass data r16", rdata[63:32], 32'h5);
`else
    chk("t4 stored busy r16", rbusy[1], 1'b1);
    chk("t4 stored data r16", rdata[63:32], 32'h0);
`endif
    step(); clr();
    @(negedge clk);
    chk("t4 busy r16 cleared", rbusy[1], 1'b0);
    chk("t4 data r16", rdata[63:32], 32'h5);
    step();
    bset(5'd18); wr1(5'd18, 32'h9);
    step(); clr();
    set_rd(1, 5'd18);
    @(negedge clk);
    chk("t4 set wins r18", rbusy[1], 1'b1);
    chk("t4 data r18", rdata[63:32], 32'h9);
    step();
    bset(5'd20);
    step(); clr();
    wr0(5'd20, 32'h3);
    step(); clr();
    set_rd(0, 5'd20);
    @(negedge clk);
    chk("t4 we0 keeps busy r20", rbusy[0], 1'b1);
    chk("t4 data r20", rdata[31:0], 32'h3);

    // 5. same-cycle visibility of a load write
    step();
    wr0(5'd31, 32'h1111);
    step(); clr();
    set_rd(0, 5'd31); dbg_addr = 5'd31;
    wr1(5'd31, 32'hCAFE);
    @(negedge clk);
`ifdef REGFILE_BYPASS_EN
    chk("t5 bypass r31", rdata[31:0], 32'hCAFE);
`else
    chk("t5 old r31", rdata[31:0], 32'h1111);
`endif
    chk("t5 dbg raw r31", dbg_data, 32'h1111);
    step(); clr();
    @(negedge clk);
    chk("t5 next r31", rdata[31:0], 32'hCAFE);

    // 6. small configuration: four independent ports
    step();
    s_we0 = 1; s_waddr0 = 3'd7; s_wdata0 = 16'hA5A5;
    s_we1 = 1; s_waddr1 = 3'd3; s_wdata1 = 16'h0303;
    step(); clr();
    s_we0 = 1; s_waddr0 = 3'd0; s_wdata0 = 16'hFFFF;
    s_we1 = 1; s_waddr1 = 3'd1; s_wdata1 = 16'h1111;
    s_busy_set = 1; s_busy_addr = 3'd2;
    step(); clr();
    s_raddr = {3'd2, 3'd0, 3'd3, 3'd7};
    s_dbg_addr = 3'd1;
    @(negedge clk);
    chk("t6 s port0 r7", s_rdata[15:0], 16'hA5A5);
    chk("t6 s port1 r3", s_rdata[31:16], 16'h0303);
    chk("t6 s port2 r0", s_rdata[47:32], 16'h0000);
    chk("t6 s port3 r2", s_rdata[63:48], 16'h0000);
    chk("t6 s rbusy", s_rbusy, 4'b1000);
    chk("t6 s dbg r1", s_dbg_data, 16'h1111);
    repeat (3) step();
    @(negedge clk);
    chk("t6 s r7 holds", s_rdata[15:0], 16'hA5A5);

    // walk every entry of both instances; the per-cycle model compare checks it
    step();
    for (int i = 1; i < 32; i++) begin
      clr();
      wr0(i[AW-1:0], i * 32'h01010101);
      if (i % 2 == 0) wr1(i[AW-1:0] - 5'd1, ~(i * 32'h00010001));
      if (i % 3 == 0) bset(i[AW-1:0]);
      set_rd(0, i[AW-1:0] - 5'd1); set_rd(1, i[AW-1:0]);
      dbg_addr = i[AW-1:0] - 5'd1;
      s_we0 = 1; s_waddr0 = i[SAW-1:0]; s_wdata0 = i[15:0] * 16'h0101;
      s_we1 = (i % 4 == 1); s_waddr1 = i[SAW-1:0] + 3'd1; s_wdata1 = 16'hF000 | i[15:0];
      s_busy_set = (i % 5 == 0); s_busy_addr = i[SAW-1:0] + 3'd1;
      s_raddr = {i[SAW-1:0] + 3'd1, i[SAW-1:0], i[SAW-1:0] - 3'd1, 3'd0};
      s_dbg_addr = i[SAW-1:0];
      step();
    end
    clr();
    repeat (2) step();
    @(negedge clk);

    check_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
